// File: rtl/wb_write_port_ctrl_if.sv
// wb_write_port_ctrl_if: pipeline, load-response and register-file write-port signals
interface wb_write_port_ctrl_if #(parameter int DEPTH = 4);
  logic alu_wb_en;
  logic [3:0] alu_dest;
  logic [31:0] alu_result;
  logic ld_issue;
  logic [3:0] ld_issue_dest;
  logic ld_rsp_valid;
  logic ld_rsp_ready;
  logic [3:0] ld_rsp_dest;
  logic [31:0] ld_rsp_data;
  logic wb_en;
  logic [3:0] dest_wb;
  logic [31:0] result_wb;
  logic [15:0] busy_mask;
  logic [$clog2(DEPTH):0] q_count;
  modport master (
    output alu_wb_en, alu_dest, alu_result, ld_issue, ld_issue_dest,
    output ld_rsp_valid, ld_rsp_dest, ld_rsp_data,
    input ld_rsp_ready, wb_en, dest_wb, result_wb, busy_mask, q_count
  );
  modport slave (
    input alu_wb_en, alu_dest, alu_result, ld_issue, ld_issue_dest,
    input ld_rsp_valid, ld_rsp_dest, ld_rsp_data,
    output ld_rsp_ready, wb_en, dest_wb, result_wb, busy_mask, q_count
  );
endinterface

// File: rtl/wb_write_port_ctrl.sv
// wb_write_port_ctrl: arbitrates the register-file write port between pipeline results and queued load responses
module wb_write_port_ctrl #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  wb_write_port_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [35:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic push, pop;
  logic [15:0] busy, set_m, clr_m;
  logic wb_en;
  logic [3:0] dest;
  logic [31:0] result;
  assign bus.ld_rsp_ready = !rst && (count != (AW+1)'(DEPTH));
  assign push = bus.ld_rsp_valid && bus.ld_rsp_ready;
  assign pop = !bus.alu_wb_en && (count != '0);
  assign set_m = bus.ld_issue ? 16'(1) << bus.ld_issue_dest : '0;
  assign clr_m = pop ? 16'(1) << mem[head][35:32] : '0;
  assign bus.wb_en = wb_en;
  assign bus.dest_wb = dest;
  assign bus.result_wb = result;
  assign bus.busy_mask = busy;
  assign bus.q_count = count;
  always_ff @(posedge clk)
    if (push) mem[tail] <= {bus.ld_rsp_dest, bus.ld_rsp_data};
  // set_m is OR-ed after clearing so a same-edge issue to the popped register wins
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      busy <= '0;
      wb_en <= 1'b0;
      dest <= '0;
      result <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      busy <= (busy & ~clr_m) | set_m;
      wb_en <= bus.alu_wb_en || pop;
      if (bus.alu_wb_en || pop)
        {dest, result} <= bus.alu_wb_en ? {bus.alu_dest, bus.alu_result} : mem[head];
    end
  end
endmodule

// File: tb/tb_wb_write_port_ctrl.sv
// tb_wb_write_port_ctrl: queue-based reference model with per-cycle compare, directed scenarios and random traffic
module tb_wb_write_port_ctrl;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  wb_write_port_ctrl_if #(.DEPTH(DEPTH)) bus ();
  wb_write_port_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [35:0] mq [$];
  logic m_wb_en = 0;
  logic [3:0] m_dest = 0;
  logic [31:0] m_res = 0;
  logic [15:0] m_busy = 0;
  logic m_push = 0;
  bit chk_en = 0;

  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // reference: a queue of accepted responses; ALU first, else oldest response
  always @(posedge clk) begin
    logic [35:0] e;
    m_push = 0;
    if (rst) begin
      mq.delete();
      m_busy = 0;
      m_wb_en = 0;
      m_dest = 0;
      m_res = 0;
    end else begin
      m_push = bus.ld_rsp_valid && (mq.size() < DEPTH);
      if (bus.alu_wb_en) begin
        m_wb_en = 1;
        m_dest = bus.alu_dest;
        m_res = bus.alu_result;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wb_en = 1;
        {m_dest, m_res} = e;
        m_busy[e[35:32]] = 0;
      end else m_wb_en = 0;
      if (bus.ld_issue) m_busy[bus.ld_issue_dest] = 1;
      if (m_push) mq.push_back({bus.ld_rsp_dest, bus.ld_rsp_data});
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("wb_en", 32'(bus.wb_en), 32'(m_wb_en));
    check("dest_wb", 32'(bus.dest_wb), 32'(m_dest));
    check("result_wb", bus.result_wb, m_res);
    check("busy_mask", 32'(bus.busy_mask), 32'(m_busy));
    check("q_count", 32'(bus.q_count), mq.size());
    check("ld_rsp_ready", 32'(bus.ld_rsp_ready), 32'(!rst && mq.size() < DEPTH));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(logic v, logic [3:0] d, logic [31:0] x);
    bus.ld_rsp_valid = v;
    bus.ld_rsp_dest = d;
    bus.ld_rsp_data = x;
  endtask

  initial begin
    bus.alu_wb_en = 0; bus.alu_dest = 0; bus.alu_result = 0;
    bus.ld_issue = 0; bus.ld_issue_dest = 0;
    rsp(0, 0, 0);
    // 1: reset then idle
    cyc();
    chk_en = 1;
    @(negedge clk);
    check("t1_ready_in_rst", 32'(bus.ld_rsp_ready), 0);
    cyc();
    rst = 0;
    cyc();
    @(negedge clk);
    check("t1_wb_en", 32'(bus.wb_en), 0);
    check("t1_dest", 32'(bus.dest_wb), 0);
    check("t1_result", bus.result_wb, 0);
    check("t1_busy", 32'(bus.busy_mask), 0);
    check("t1_q", 32'(bus.q_count), 0);
    check("t1_ready", 32'(bus.ld_rsp_ready), 1);
    // 2: single pipeline write
    bus.alu_wb_en = 1; bus.alu_dest = 5; bus.alu_result = 32'h1234;
    cyc();
    bus.alu_wb_en = 0;
    @(negedge clk);
    check("t2_wb_en", 32'(bus.wb_en), 1);
    check("t2_dest", 32'(bus.dest_wb), 5);
    check("t2_result", bus.result_wb, 32'h1234);
    cyc();
    @(negedge clk);
    check("t2_wb_en_off", 32'(bus.wb_en), 0);
    check("t2_dest_hold", 32'(bus.dest_wb), 5);
    // 3: load lifecycle
    bus.ld_issue = 1; bus.ld_issue_dest = 3;
    cyc();
    bus.ld_issue = 0;
    @(negedge clk);
    check("t3_busy_set", 32'(bus.busy_mask), 32'h8);
    cyc();
    cyc();
    rsp(1, 3, 32'hDEADBEEF);
    cyc();
    rsp(0, 0, 0);
    @(negedge clk);
    check("t3_q", 32'(bus.q_count), 1);
    check("t3_busy_queued", 32'(bus.busy_mask), 32'h8);
    check("t3_no_bypass", 32'(bus.wb_en), 0);
    cyc();
    @(negedge clk);
    check("t3_wb_en", 32'(bus.wb_en), 1);
    check("t3_dest", 32'(bus.dest_wb), 3);
    check("t3_result", bus.result_wb, 32'hDEADBEEF);
    check("t3_busy_clr", 32'(bus.busy_mask), 0);
    // 4: starvation then in-order drain
    bus.alu_wb_en = 1; bus.alu_dest = 9; bus.alu_result = 32'h99;
    for (int i = 1; i <= 5; i++) begin
      rsp(1, 4'(i), 32'h100 + i);
      cyc();
    end
    @(negedge clk);
    check("t4_q_full", 32'(bus.q_count), 4);
    check("t4_ready_low", 32'(bus.ld_rsp_ready), 0);
    bus.alu_wb_en = 0;
    cyc();
    @(negedge clk);
    check("t4_d1", 32'(bus.dest_wb), 1);
    check("t4_r1", bus.result_wb, 32'h101);
    check("t4_q3", 32'(bus.q_count), 3);
    cyc();
    rsp(0, 0, 0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      check("t4_wb_en", 32'(bus.wb_en), 1);
      check("t4_dest", 32'(bus.dest_wb), i);
      check("t4_result", bus.result_wb, 32'h100 + i);
      if (i < 5) cyc();
    end
    check("t4_q_empty", 32'(bus.q_count), 0);
    // 5: set/clear collision on R7
    bus.ld_issue = 1; bus.ld_issue_dest = 7;
    cyc();
    bus.ld_issue = 0;
    rsp(1, 7, 32'h77);
    cyc();
    rsp(0, 0, 0);
    bus.ld_issue = 1; bus.ld_issue_dest = 7;
    cyc();
    bus.ld_issue = 0;
    @(negedge clk);
    check("t5_dest", 32'(bus.dest_wb), 7);
    check("t5_result", bus.result_wb, 32'h77);
    check("t5_busy", 32'(bus.busy_mask), 32'h80);
    // 6: reset with a partially filled queue
    for (int i = 5; i <= 6; i++) begin
      bus.ld_issue = 1; bus.ld_issue_dest = 4'(i);
      cyc();
    end
    bus.ld_issue = 0;
    bus.alu_wb_en = 1;
    for (int i = 5; i <= 7; i++) begin
      rsp(1, 4'(i), 32'h500 + i);
      cyc();
    end
    rsp(0, 0, 0);
    @(negedge clk);
    check("t6_q", 32'(bus.q_count), 3);
    check("t6_busy", 32'(bus.busy_mask), 32'hE0);
    rst = 1; bus.alu_wb_en = 0;
    cyc();
    rst = 0;
    @(negedge clk);
    check("t6_q_rst", 32'(bus.q_count), 0);
    check("t6_busy_rst", 32'(bus.busy_mask), 0);
    check("t6_wb_rst", 32'(bus.wb_en), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      check("t6_no_stale_write", 32'(bus.wb_en), 0);
    end
    // random traffic, alternating light and heavy ALU phases
    for (int c = 0; c < 3000; c++) begin
      int th;
      th = ((c / 500) % 2) != 0 ? 90 : 35;
      rst = ($urandom_range(0, 249) == 0);
      bus.alu_wb_en = $urandom_range(0, 99) < th;
      bus.alu_dest = 4'($urandom);
      bus.alu_result = $urandom;
      bus.ld_issue = ($urandom_range(0, 3) == 0);
      bus.ld_issue_dest = 4'($urandom);
      if (rst) rsp(0, 0, 0);
      else if (!bus.ld_rsp_valid || m_push)
        rsp(1'($urandom_range(0, 1)), 4'($urandom), $urandom);
      cyc();
    end
    rst = 0;
    bus.alu_wb_en = 0; bus.ld_issue = 0;
    rsp(0, 0, 0);
    for (int i = 0; i < 8; i++) cyc();
    @(negedge clk);
    check("final_drained", 32'(bus.q_count), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
